// File: rtl/song_reader_if.sv
// Song reader bus: song control, ROM read port and the note presented to the comparator.
interface song_reader_if #(
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 2,
  parameter int DATA_W = 10
);
  logic [SEL_W-1:0]        song_sel;
  logic                    start;
  logic                    read_en;
  logic [ADDR_W-1:0]       rom_addr;
  logic [DATA_W-1:0]       rom_data;
  logic [DATA_W-1:0]       data_out;
  logic                    data_valid;
  logic                    busy;
  logic                    done;
  logic [ADDR_W-SEL_W-1:0] note_idx;

  // The sequencer side drives the ROM address and the note outputs.
  modport master (
    input  song_sel, start, read_en, rom_data,
    output rom_addr, data_out, data_valid, busy, done, note_idx
  );

  modport slave (
    output song_sel, start, read_en, rom_data,
    input  rom_addr, data_out, data_valid, busy, done, note_idx
  );
endinterface

// File: rtl/song_reader.sv
// Learn-mode song sequencer: walks one song region of the note ROM, one note per advance.
// Define SONG_READER_EDGE_EN to accept advances only on a rising edge of read_en.
module song_reader #(
  parameter int ADDR_W = 8,
  parameter int SEL_W  = 2,
  parameter int DATA_W = 10
) (
  input logic clk,
  input logic rst,
  song_reader_if.master bus
);
  localparam int OFF_W = ADDR_W - SEL_W;
  localparam logic [OFF_W-1:0] LAST_OFF = {OFF_W{1'b1}};

  typedef enum logic [1:0] {IDLE, FETCH, PRESENT, DONE} state_t;

  state_t           state;
  logic [SEL_W-1:0] sel_q;
  logic             fetch_wait;
  logic [OFF_W-1:0] next_idx;
  logic             advance;

  assign next_idx = bus.note_idx + 1'b1;

`ifdef SONG_READER_EDGE_EN
  logic read_en_q;

  // Reset to 1 so a read_en already high when leaving reset is not taken as an edge.
  always_ff @(posedge clk) begin
    if (rst) read_en_q <= 1'b1;
    else     read_en_q <= bus.read_en;
  end

  assign advance = (state == PRESENT) && bus.read_en && !read_en_q;
`else
  assign advance = (state == PRESENT) && bus.read_en;
`endif

  // FETCH spends one cycle waiting for the synchronous ROM, then captures on exit.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      sel_q         <= '0;
      fetch_wait    <= 1'b0;
      bus.rom_addr  <= '0;
      bus.data_out  <= '0;
      bus.data_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.note_idx  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state          <= FETCH;
            sel_q          <= bus.song_sel;
            fetch_wait     <= 1'b1;
            bus.note_idx   <= '0;
            bus.rom_addr   <= {bus.song_sel, {OFF_W{1'b0}}};
            bus.data_valid <= 1'b0;
            bus.busy       <= 1'b1;
            bus.done       <= 1'b0;
          end
        end

        FETCH: begin
          if (fetch_wait) begin
            fetch_wait <= 1'b0;
          end else if (bus.rom_data[DATA_W-1:2] != '0) begin
            state          <= PRESENT;
            bus.data_out   <= bus.rom_data;
            bus.data_valid <= 1'b1;
          end else begin
            // End marker keeps the last real note on data_out; an empty song shows 0.
            state          <= DONE;
            if (bus.note_idx == '0) bus.data_out <= '0;
            bus.data_valid <= 1'b0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b1;
          end
        end

        PRESENT: begin
          if (advance) begin
            bus.data_valid <= 1'b0;
            if (bus.note_idx == LAST_OFF) begin
              state    <= DONE;
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
            end else begin
              state        <= FETCH;
              fetch_wait   <= 1'b1;
              bus.note_idx <= next_idx;
              bus.rom_addr <= {sel_q, next_idx};
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_song_reader.sv
// Scoreboard bench for song_reader: stimulus pushes expected notes, a monitor checks each presented note.
module tb_song_reader;
  localparam int ADDR_W = 8;
  localparam int SEL_W  = 2;
  localparam int DATA_W = 10;

  logic clk;
  logic rst;

  song_reader_if #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .DATA_W(DATA_W)) bus ();

  song_reader #(.ADDR_W(ADDR_W), .SEL_W(SEL_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [DATA_W-1:0] rom [0:(1<<ADDR_W)-1];
  logic [15:0]       exp_q [$];
  int tests = 0;
  int fails = 0;
  bit track_addr = 0;
  bit addr_over = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous ROM model: data follows the address by one clock.
  always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_note(input int idx, input logic [DATA_W-1:0] word);
    exp_q.push_back({idx[5:0], word});
  endtask

  task automatic check_reset_outputs(input string tag);
    check_output({tag, " data_out"},   32'(bus.data_out), 0);
    check_output({tag, " data_valid"}, 32'(bus.data_valid), 0);
    check_output({tag, " busy"},       32'(bus.busy), 0);
    check_output({tag, " done"},       32'(bus.done), 0);
    check_output({tag, " rom_addr"},   32'(bus.rom_addr), 0);
    check_output({tag, " note_idx"},   32'(bus.note_idx), 0);
  endtask

  task automatic apply_stimulus_start(input logic [SEL_W-1:0] sel);
    bus.song_sel = sel;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  task automatic wait_valid(input string name, input int budget);
    int n = 0;
    while (!bus.data_valid && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (!bus.data_valid) begin
      fails++;
      $display("[TB] FAIL %s: data_valid=0 after %0d cycles, expected 1", name, budget);
    end
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (!bus.done && n < budget) begin
      tick();
      n++;
    end
    tests++;
    if (!bus.done) begin
      fails++;
      $display("[TB] FAIL %s: done=0 after %0d cycles, expected 1", name, budget);
    end
  endtask

  task automatic pulse_read();
    bus.read_en = 1'b1;
    tick();
    bus.read_en = 1'b0;
  endtask

  // Monitor: every rising edge of data_valid is one presented note.
  initial begin : monitor
    logic prev_valid;
    logic [15:0] exp;
    prev_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (track_addr && bus.rom_addr >= 8'd64) addr_over = 1'b1;
      if (bus.data_valid && !prev_valid) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL note: unexpected note idx=%0d word=%0h", bus.note_idx, bus.data_out);
        end else begin
          exp = exp_q.pop_front();
          if ({2'b00, bus.note_idx, bus.data_out} !== exp) begin
            fails++;
            $display("[TB] FAIL note: got idx=%0d word=%0h, expected idx=%0d word=%0h",
                     bus.note_idx, bus.data_out, exp[15:10], exp[9:0]);
          end
        end
      end
      prev_valid = bus.data_valid;
    end
  end

  initial begin : stimulus
    logic [7:0] btn;
    for (int a = 0; a < (1<<ADDR_W); a++) rom[a] = '0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.read_en  = 1'b0;
    bus.song_sel = '0;
    repeat (3) tick();
    rst = 1'b0;
    check_reset_outputs("reset");

    // read_en in IDLE is ignored.
    bus.read_en = 1'b1;
    repeat (3) tick();
    bus.read_en = 1'b0;
    check_output("idle read busy", 32'(bus.busy), 0);
    check_output("idle read rom_addr", 32'(bus.rom_addr), 0);
    tick();

    // Song 1, single note then end marker.
    rom[64] = 10'h201;
    rom[65] = 10'h000;
    push_note(0, 10'h201);
    apply_stimulus_start(2'd1);
    check_output("s1 rom_addr", 32'(bus.rom_addr), 64);
    check_output("s1 busy", 32'(bus.busy), 1);
    check_output("s1 valid n+1", 32'(bus.data_valid), 0);
    tick();
    check_output("s1 valid n+1", 32'(bus.data_valid), 0);
    tick();
    check_output("s1 valid n+2", 32'(bus.data_valid), 1);
    check_output("s1 data n+2", 32'(bus.data_out), 32'h201);
    pulse_read();
    check_output("s1 adv valid", 32'(bus.data_valid), 0);
    wait_done("s1 done", 10);
    check_output("s1 busy end", 32'(bus.busy), 0);
    check_output("s1 data held", 32'(bus.data_out), 32'h201);

    // Song 0 with three words, pulsed advances.
    rom[0] = 10'h201;
    rom[1] = 10'h102;
    rom[2] = 10'h000;
    push_note(0, 10'h201);
    push_note(1, 10'h102);
    apply_stimulus_start(2'd0);
    wait_valid("s0 note0", 10);
    pulse_read();
    wait_valid("s0 note1", 10);
    pulse_read();
    wait_done("s0 done", 10);
    check_output("s0 busy", 32'(bus.busy), 0);
    check_output("s0 note_idx", 32'(bus.note_idx), 2);
    check_output("s0 data held", 32'(bus.data_out), 32'h102);

    // read_en held high for 10 cycles.
    rom[0] = 10'h201;
    rom[1] = 10'h201;
    rom[2] = 10'h201;
    rom[3] = 10'h000;
    push_note(0, 10'h201);
    push_note(1, 10'h201);
`ifndef SONG_READER_EDGE_EN
    push_note(2, 10'h201);
`endif
    apply_stimulus_start(2'd0);
    wait_valid("hold note0", 10);
    bus.read_en = 1'b1;
    repeat (10) tick();
    bus.read_en = 1'b0;
`ifdef SONG_READER_EDGE_EN
    check_output("hold done", 32'(bus.done), 0);
    check_output("hold busy", 32'(bus.busy), 1);
    check_output("hold valid", 32'(bus.data_valid), 1);
    check_output("hold note_idx", 32'(bus.note_idx), 1);
`else
    check_output("hold done", 32'(bus.done), 1);
    check_output("hold busy", 32'(bus.busy), 0);
    check_output("hold note_idx", 32'(bus.note_idx), 3);
    check_output("hold data held", 32'(bus.data_out), 32'h201);
`endif
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("reset2");

    // Full 64-note song 0; song 1 starts with a real note so a wrap would show.
    for (int i = 0; i < 64; i++) begin
      btn = 8'd1 << (i % 8);
      rom[i] = {btn, 2'(i % 4)};
      push_note(i, {btn, 2'(i % 4)});
    end
    rom[64] = 10'h201;
    track_addr = 1'b1;
    apply_stimulus_start(2'd0);
    for (int i = 0; i < 64; i++) begin
      wait_valid("long note", 10);
      if (i == 5) begin
        bus.song_sel = 2'd2;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        check_output("start in present valid", 32'(bus.data_valid), 1);
        check_output("start in present idx", 32'(bus.note_idx), 5);
        check_output("start in present addr", 32'(bus.rom_addr), 5);
        pulse_read();
      end else if (i == 6) begin
        bus.start   = 1'b1;
        bus.read_en = 1'b1;
        tick();
        bus.start   = 1'b0;
        bus.read_en = 1'b0;
        check_output("start+read valid", 32'(bus.data_valid), 0);
        check_output("start+read idx", 32'(bus.note_idx), 7);
        check_output("start+read addr", 32'(bus.rom_addr), 7);
      end else begin
        pulse_read();
      end
    end
    wait_done("long done", 10);
    check_output("long note_idx", 32'(bus.note_idx), 63);
    check_output("long rom_addr", 32'(bus.rom_addr), 63);
    check_output("long valid", 32'(bus.data_valid), 0);
    tick();
    tick();
    track_addr = 1'b0;
    check_output("long addr wrap", 32'(addr_over), 0);

    // Reset during FETCH aborts the song.
    apply_stimulus_start(2'd1);
    check_output("abort busy", 32'(bus.busy), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("abort");
    bus.read_en = 1'b1;
    repeat (3) tick();
    bus.read_en = 1'b0;
    check_output("abort idle busy", 32'(bus.busy), 0);
    check_output("abort idle valid", 32'(bus.data_valid), 0);
    check_output("abort idle addr", 32'(bus.rom_addr), 0);

    repeat (4) tick();
    check_output("scoreboard empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end
endmodule
